spi_slave_core: RTL
===================

// Module: spi_slave_core
// PURPOSE
//  Synthesizable SPI slave (responder) for the DUT side of the SPI bench; counterpart of the master driver.
//  Oversamples sclk/cs/mosi on the system clock, shifts words in on sample edges, drives miso on shift edges.
//  Supports CPOL/CPHA modes 0-3 and 1/2/4-lane (single/dual/quad) transfers, MSB first.
//  Exchanges whole words with core logic over tx valid/ready and rx valid pulse interfaces.
// PARAMETERS
//  DATA_WIDTH  8      word length in bits; must be a multiple of 4
//  TX_IDLE     'hFF   word shifted out when no tx word is available (underrun)
//  SYNC_STAGES 2      synchronizer flops on sclk, cs, mosi[3:0] (>=2)
// PORTS
//  clk            in   1    system clock; must be >= 8x sclk frequency
//  rst            in   1    synchronous reset, active high
//  cfg_cpol       in   1    clock polarity; latched at cs assertion
//  cfg_cpha       in   1    clock phase; latched at cs assertion
//  cfg_lane_mode  in   2    00 single, 01 dual, 10 quad, 11 treated as single; latched at cs assertion
//  sclk           in   1    SPI clock from master (asynchronous)
//  cs             in   1    chip select, active low (asynchronous)
//  mosi           in   4    master-out lanes mosi3..mosi0
//  miso           out  4    slave-out lanes miso3..miso0
//  miso_oe        out  4    per-lane output enable
//  tx_data        in   DW   next word to send
//  tx_valid       in   1    tx_data valid
//  tx_ready       out  1    1-cycle pulse: tx_data consumed this cycle
//  tx_underrun    out  1    1-cycle pulse: TX_IDLE loaded instead of tx_data
//  rx_data        out  DW   last received word; held until next word completes
//  rx_valid       out  1    1-cycle pulse: rx_data updated
//  frame_err      out  1    1-cycle pulse: cs deasserted mid-word
//  busy           out  1    high while in ACTIVE state
// BEHAVIOUR
//  Reset: state IDLE; miso=0, miso_oe=0, rx_data=0, all pulses 0, busy=0, bit counter 0.
//  Inputs pass SYNC_STAGES flops then 1 edge-detect flop; all latencies below count from the pin edge.
//  Leading edge = rise if CPOL=0 else fall. CPHA=0: sample on leading, shift on trailing. CPHA=1: swapped.
//  Lanes L = 1/2/4; beats per word N = DATA_WIDTH/L. Per beat, bits {lane L-1..lane0} = next L MSBs.
//  miso_oe = 1 only on lanes in use while busy; unused lanes and all lanes in IDLE drive miso=0, oe=0.
//  FSM IDLE -> ACTIVE on synced cs falling: latch cfg, counter=0.
//   CPHA=0: load tx word in same cycle; miso shows first beat immediately.
//   CPHA=1: load tx word on first shift edge of each word and drive its first beat.
//  Load: tx_valid=1 -> shift reg<=tx_data, tx_ready pulse; else shift reg<=TX_IDLE, tx_underrun pulse.
//  Sample edge: rx shift reg <= {rx[DW-1-L:0], mosi[L-1:0]}; counter++.
//  Counter reaches N: rx_data<=assembled word, rx_valid pulse SYNC_STAGES+1 clk after pin edge; counter=0.
//  CPHA=0 back-to-back: the shift edge after the last sample loads the next word (not a shift).
//  Shift edge otherwise: shift reg left by L, miso updates SYNC_STAGES+1 clk after pin edge.
//  ACTIVE -> IDLE on synced cs rising: counter!=0 -> frame_err pulse, partial word dropped, no rx_valid.
//  cs rising and final sample edge in same cycle: word completes (rx_valid), no frame_err.
//  cfg changes while busy ignored. sclk edges while cs high ignored. rst mid-transfer -> IDLE immediately.
//  Loaded tx word never changes mid-word regardless of tx_valid activity.
// TESTING
//  Mode 0, single, tx_data=0x3C valid, master sends 0xA5 -> rx_data=0xA5, one rx_valid; miso 0,0,1,1,1,1,0,0; one tx_ready.
//  Mode 3, quad, tx_data=0x96, master sends 0x5A in 2 beats -> rx_data=0x5A; miso beats 4'h9,4'h6; miso_oe=4'hF.
//  Mode 1, single, tx_valid=0 -> tx_underrun pulse, miso shifts 0xFF, rx still captured.
//  cs released after 5 bits of 0xA5 -> frame_err pulse, no rx_valid, rx_data unchanged, miso_oe=0.
//  Mode 0, dual, 3 back-to-back words 0x11,0x22,0x33 with cs held low -> 3 rx_valid, 3 tx_ready, bit order intact.
//  rst asserted mid-word -> next clk miso_oe=0, busy=0; next cs frame received correctly from bit 0.

Source files
------------

// File: rtl/spi_slave_core_if.sv
// Core-side word exchange between the SPI slave and its client logic.
// The slave modport is the SPI responder; master is the client supplying tx words.
interface spi_slave_core_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_underrun;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  frame_err;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_underrun, rx_data, rx_valid, frame_err
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_underrun, rx_data, rx_valid, frame_err
    );
endinterface

// File: rtl/spi_slave_core.sv
// Oversampling SPI slave: CPOL/CPHA modes 0-3, single/dual/quad lanes, MSB first.
// Pins are synchronized, edge-detected, then words are shifted in/out on the system clock.
module spi_slave_core #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE     = 'hFF,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_cpol,
    input  logic            cfg_cpha,
    input  logic [1:0]      cfg_lane_mode,
    input  logic            sclk,
    input  logic            cs,
    input  logic [3:0]      mosi,
    output logic [3:0]      miso,
    output logic [3:0]      miso_oe,
    output logic            busy,
    spi_slave_core_if.slave core
);
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync;
    logic [3:0]              mosi_sync [SYNC_STAGES];
    logic                    sclk_prev, cs_prev;
    logic                    cpol_q, cpol_d, cpha_q, cpha_d;
    logic [1:0]              lane_q, lane_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc, beats;
    logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d, tx_shifted;
    logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d, rx_shifted;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    pend_q, pend_d;
    logic                    tx_ready_q, tx_ready_d, under_q, under_d;
    logic                    rx_valid_q, rx_valid_d, ferr_q, ferr_d;
    logic                    do_load;

    logic       sclk_s, cs_s;
    logic [3:0] mosi_s;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic       lead_edge, trail_edge, sample_edge, shift_edge;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign cnt_inc     = cnt_q + CW'(1);

    // Lane-dependent datapath views; lane mode 11 falls back to single.
    always_comb begin
        case (lane_q)
            2'b01: begin
                beats      = CW'(DATA_WIDTH / 2);
                tx_shifted = tx_sh_q << 2;
                rx_shifted = {rx_sh_q[DATA_WIDTH-3:0], mosi_s[1:0]};
            end
            2'b10: begin
                beats      = CW'(DATA_WIDTH / 4);
                tx_shifted = tx_sh_q << 4;
                rx_shifted = {rx_sh_q[DATA_WIDTH-5:0], mosi_s[3:0]};
            end
            default: begin
                beats      = CW'(DATA_WIDTH);
                tx_shifted = tx_sh_q << 1;
                rx_shifted = {rx_sh_q[DATA_WIDTH-2:0], mosi_s[0]};
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lane_d     = lane_q;
        cnt_d      = cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        pend_d     = pend_q;
        tx_ready_d = 1'b0;
        under_d    = 1'b0;
        rx_valid_d = 1'b0;
        ferr_d     = 1'b0;
        do_load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StActive;
                    cpol_d  = cfg_cpol;
                    cpha_d  = cfg_cpha;
                    lane_d  = cfg_lane_mode;
                    cnt_d   = '0;
                    rx_sh_d = '0;
                    tx_sh_d = '0;
                    // CPHA=0 must present the first beat before the first sclk edge.
                    do_load = ~cfg_cpha;
                    pend_d  = cfg_cpha;
                end
            end
            StActive: begin
                if (sample_edge) begin
                    rx_sh_d = rx_shifted;
                    if (cnt_inc == beats) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_shifted;
                        rx_valid_d = 1'b1;
                        pend_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (shift_edge) begin
                    if (pend_q) begin
                        do_load = 1'b1;
                        pend_d  = 1'b0;
                    end else begin
                        tx_sh_d = tx_shifted;
                    end
                end
                // A sample completing the word in this same cycle leaves cnt_d at zero.
                if (cs_rise) begin
                    state_d = StIdle;
                    ferr_d  = (cnt_d != '0);
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (do_load) begin
            if (core.tx_valid) begin
                tx_sh_d    = core.tx_data;
                tx_ready_d = 1'b1;
            end else begin
                tx_sh_d = TX_IDLE;
                under_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync  <= '0;
            cs_sync    <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) mosi_sync[i] <= '0;
            sclk_prev  <= 1'b0;
            cs_prev    <= 1'b1;
            state_q    <= StIdle;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lane_q     <= 2'b00;
            cnt_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            pend_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            under_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) mosi_sync[i] <= mosi_sync[i-1];
            sclk_prev  <= sclk_s;
            cs_prev    <= cs_s;
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lane_q     <= lane_d;
            cnt_q      <= cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            pend_q     <= pend_d;
            tx_ready_q <= tx_ready_d;
            under_q    <= under_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        miso    = 4'b0000;
        miso_oe = 4'b0000;
        if (state_q == StActive) begin
            case (lane_q)
                2'b01: begin
                    miso[1:0] = tx_sh_q[DATA_WIDTH-1 -: 2];
                    miso_oe   = 4'b0011;
                end
                2'b10: begin
                    miso    = tx_sh_q[DATA_WIDTH-1 -: 4];
                    miso_oe = 4'b1111;
                end
                default: begin
                    miso[0] = tx_sh_q[DATA_WIDTH-1];
                    miso_oe = 4'b0001;
                end
            endcase
        end
    end

    assign busy             = (state_q == StActive);
    assign core.tx_ready    = tx_ready_q;
    assign core.tx_underrun = under_q;
    assign core.rx_data     = rx_data_q;
    assign core.rx_valid    = rx_valid_q;
    assign core.frame_err   = ferr_q;
endmodule
